rgbled_ctrl: RTL and testbench

// - Sequencer for the ws281x_drv WS2812 chain driver: holds one colour register per LED in the

---
 rtl/rgbled_ctrl_pkg.sv | 22 ++
 rtl/rgbled_scale.sv | 28 ++
 rtl/rgbled_ctrl.sv | 126 ++++++++++++
 tb/tb_rgbled_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgbled_ctrl_pkg.sv
// Shared types for the WS2812 frame sequencer: colour struct, FSM states, wire-order helper.
package rgbled_ctrl_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } rgbled_state_e;

  // WS2812 shifts green first, then red, then blue.
  function automatic logic [23:0] to_wire_order(input rgb_t c);
    return {c.g, c.r, c.b};
  endfunction

endpackage

// File: rtl/rgbled_scale.sv
// Combinational 3-channel brightness scaler: out = (c * (brightness + 1)) >> 8.
// Only instantiated when RGBLED_CTRL_BRIGHTNESS_EN is defined.
module rgbled_scale
  import rgbled_ctrl_pkg::*;
(
  input  rgb_t       i_colour,
  input  logic [7:0] i_brightness,
  output rgb_t       o_colour
);

  logic [8:0] w_gain;
  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;
  logic [7:0] w_unused_lo_r;
  logic [7:0] w_unused_lo_g;
  logic [7:0] w_unused_lo_b;

  // Gain of 256 makes brightness 255 an exact pass-through.
  assign w_gain = {1'b0, i_brightness} + 9'd1;

  assign {w_r, w_unused_lo_r} = 16'(i_colour.r) * 16'(w_gain);
  assign {w_g, w_unused_lo_g} = 16'(i_colour.g) * 16'(w_gain);
  assign {w_b, w_unused_lo_b} = 16'(i_colour.b) * 16'(w_gain);

  assign o_colour = {w_r, w_g, w_b};

endmodule

// File: rtl/rgbled_ctrl.sv
// Frame sequencer feeding ws281x_drv: per-LED colour registers streamed on request or refresh.
// Optional global brightness scaling under RGBLED_CTRL_BRIGHTNESS_EN.
module rgbled_ctrl
  import rgbled_ctrl_pkg::*;
#(
  parameter int unsigned NumLeds       = 2,
  parameter int unsigned AddrWidth     = 6,
  parameter int unsigned RefreshCycles = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 reg_we_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic [23:0]          reg_wdata_i,
  input  logic                 update_i,
  input  logic [7:0]           brightness_i,
  output logic                 busy_o,
  output logic                 drv_go_o,
  input  logic                 drv_idle_i,
  output logic [23:0]          drv_data_o,
  output logic                 drv_valid_o,
  output logic                 drv_last_o,
  input  logic                 drv_ack_i
);

  localparam int unsigned          CntW    = (RefreshCycles > 1) ? $clog2(RefreshCycles) : 1;
  localparam logic [CntW-1:0]      CntWrap = CntW'((RefreshCycles > 0) ? RefreshCycles - 1 : 0);
  localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumLeds - 1);

  rgbled_state_e        r_state;
  rgbled_state_e        w_state_nxt;
  rgb_t                 r_colour [NumLeds];
  logic [AddrWidth-1:0] r_idx;
  logic [23:0]          r_data;
  logic                 r_pending;
  logic                 r_drain_first;
  logic [CntW-1:0]      r_refresh;

  logic                 w_expire;
  logic                 w_start;
  logic                 w_last;
  logic                 w_ack;
  logic                 w_load;
  logic [AddrWidth-1:0] w_rd_idx;
  rgb_t                 w_rd_colour;
  rgb_t                 w_out_colour;

  // Out-of-range addresses match no entry and are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumLeds; i++) r_colour[i] <= '0;
    end else if (reg_we_i) begin
      for (int unsigned i = 0; i < NumLeds; i++) begin
        if (reg_addr_i == AddrWidth'(i)) r_colour[i] <= rgb_t'(reg_wdata_i);
      end
    end
  end

  always_comb begin
    w_rd_colour = '0;
    for (int unsigned i = 0; i < NumLeds; i++) begin
      if (w_rd_idx == AddrWidth'(i)) w_rd_colour = r_colour[i];
    end
  end

`ifdef RGBLED_CTRL_BRIGHTNESS_EN
  rgbled_scale u_scale (
    .i_colour     (w_rd_colour),
    .i_brightness (brightness_i),
    .o_colour     (w_out_colour)
  );
`else
  logic w_unused_brightness;
  assign w_unused_brightness = ^brightness_i;
  assign w_out_colour        = w_rd_colour;
`endif

  assign w_expire = (RefreshCycles != 0) && (r_refresh == CntWrap);
  assign w_last   = (r_state == STREAM) && (r_idx == LastIdx);
  assign w_ack    = (r_state == STREAM) && drv_ack_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (update_i || r_pending || w_expire) w_state_nxt = START;
      START:   w_state_nxt = STREAM;
      STREAM:  if (w_ack && w_last) w_state_nxt = DRAIN;
      DRAIN:   if (!r_drain_first && drv_idle_i) w_state_nxt = r_pending ? START : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_start = (w_state_nxt == START);

  // The output word is fetched one index ahead so it is ready the cycle after an ack.
  assign w_rd_idx = (r_state == START) ? '0 : r_idx + AddrWidth'(1);
  assign w_load   = (r_state == START) || (w_ack && !w_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_data        <= '0;
      r_pending     <= 1'b0;
      r_drain_first <= 1'b0;
      r_refresh     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_drain_first <= (r_state == STREAM);
      if (r_state == START) r_idx <= '0;
      else if (w_ack && !w_last) r_idx <= w_rd_idx;
      if (w_load) r_data <= to_wire_order(w_out_colour);
      if (w_start) r_pending <= 1'b0;
      else if ((r_state != IDLE) && (update_i || w_expire)) r_pending <= 1'b1;
      if (RefreshCycles == 0 || w_start || w_expire) r_refresh <= '0;
      else r_refresh <= r_refresh + CntW'(1);
    end
  end

  assign busy_o      = (r_state != IDLE) || r_pending;
  assign drv_go_o    = (r_state == START);
  assign drv_valid_o = (r_state == STREAM);
  assign drv_last_o  = w_last;
  assign drv_data_o  = r_data;

endmodule

// File: tb/tb_rgbled_ctrl.sv
// Directed bench for rgbled_ctrl: on-demand frames, collapsed requests, refresh timer, NumLeds=1.
module tb_rgbled_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // DUT A: on-demand frames, driver model acks 3 cycles after each word
  logic        rst_a = 1'b0, we_a = 1'b0, upd_a = 1'b0;
  logic [5:0]  addr_a = '0;
  logic [23:0] wdata_a = '0;
  logic [7:0]  bright_a = 8'd255;
  logic        busy_a, go_a, valid_a, last_a;
  logic        idle_a = 1'b1, ack_a = 1'b0;
  logic [23:0] data_a;

  rgbled_ctrl #(.NumLeds(2), .AddrWidth(6), .RefreshCycles(0)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_a), .reg_we_i(we_a), .reg_addr_i(addr_a), .reg_wdata_i(wdata_a),
    .update_i(upd_a), .brightness_i(bright_a), .busy_o(busy_a), .drv_go_o(go_a),
    .drv_idle_i(idle_a), .drv_data_o(data_a), .drv_valid_o(valid_a), .drv_last_o(last_a),
    .drv_ack_i(ack_a)
  );

  // DUT B: refresh every 1000 cycles; DUT C: single LED. Both ack immediately.
  logic        rst_b = 1'b0, we_b = 1'b0, we_c = 1'b0, upd_c = 1'b0;
  logic [5:0]  addr_b = '0, addr_c = '0;
  logic [23:0] wdata_b = '0, wdata_c = '0;
  logic        busy_b, go_b, valid_b, last_b, busy_c, go_c, valid_c, last_c;
  logic [23:0] data_b, data_c;
  logic        ack_b, ack_c, idle_hi;
  assign ack_b   = valid_b;
  assign ack_c   = valid_c;
  assign idle_hi = 1'b1;

  rgbled_ctrl #(.NumLeds(2), .AddrWidth(6), .RefreshCycles(1000)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_b), .reg_we_i(we_b), .reg_addr_i(addr_b), .reg_wdata_i(wdata_b),
    .update_i(1'b0), .brightness_i(8'd255), .busy_o(busy_b), .drv_go_o(go_b),
    .drv_idle_i(idle_hi), .drv_data_o(data_b), .drv_valid_o(valid_b), .drv_last_o(last_b),
    .drv_ack_i(ack_b)
  );

  rgbled_ctrl #(.NumLeds(1), .AddrWidth(6), .RefreshCycles(0)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_b), .reg_we_i(we_c), .reg_addr_i(addr_c), .reg_wdata_i(wdata_c),
    .update_i(upd_c), .brightness_i(8'd255), .busy_o(busy_c), .drv_go_o(go_c),
    .drv_idle_i(idle_hi), .drv_data_o(data_c), .drv_valid_o(valid_c), .drv_last_o(last_c),
    .drv_ack_i(ack_c)
  );

  // Driver model A: counts go pulses, logs acked words, holds idle low until a latch delay
  int          cyc_a = 0, go_cnt_a = 0, go_gap_a = 0, idle_rise_a = 0, wcnt_a = 0, latch_a = 0;
  logic [24:0] words_a[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc_a++;
      if (!rst_a) begin
        ack_a = 1'b0; wcnt_a = 0; latch_a = 0; idle_a = 1'b1;
      end else begin
        if (go_a) begin
          go_cnt_a++; go_gap_a = cyc_a - idle_rise_a; idle_a = 1'b0;
        end
        if (latch_a > 0) begin
          latch_a--;
          if (latch_a == 0) begin idle_a = 1'b1; idle_rise_a = cyc_a; end
        end
        if (ack_a) ack_a = 1'b0;
        else if (valid_a) begin
          if (wcnt_a == 2) begin
            ack_a = 1'b1; wcnt_a = 0;
            words_a.push_back({last_a, data_a});
            if (last_a) latch_a = 4;
          end else wcnt_a++;
        end
      end
    end
  end

  // Monitor B: cycle count since reset release, go cycles and words
  int          cyc_b = 0;
  int          gocyc_b[$];
  logic [24:0] words_b[$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst_b) begin
        cyc_b++;
        if (go_b) gocyc_b.push_back(cyc_b);
        if (valid_b) words_b.push_back({last_b, data_b});
      end
    end
  end

  task automatic write_a(input logic [5:0] a, input logic [23:0] d);
    we_a = 1'b1; addr_a = a; wdata_a = d;
    @(negedge clk);
    we_a = 1'b0;
  endtask

  task automatic pulse_a();
    upd_a = 1'b1;
    @(negedge clk);
    upd_a = 1'b0;
  endtask

  task automatic wait_valid_a(input string tag);
    int n = 0;
    while (!valid_a && n < 50) begin @(negedge clk); n++; end
    check(tag, {31'd0, valid_a}, 32'd1);
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (busy_a && n < 400) begin @(negedge clk); n++; end
    check(tag, {31'd0, busy_a}, 32'd0);
  endtask

  task automatic clear_a();
    words_a.delete();
    go_cnt_a = 0;
  endtask

  initial begin
    int n;
    #8;
    check("rst_busy",  {31'd0, busy_a},  32'd0);
    check("rst_go",    {31'd0, go_a},    32'd0);
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_last",  {31'd0, last_a},  32'd0);
    check("rst_data",  {8'd0, data_a},   32'd0);
    #4;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    we_b = 1'b1; addr_b = 6'd0; wdata_b = 24'h112233;
    we_c = 1'b1; addr_c = 6'd0; wdata_c = 24'h445566;
    @(negedge clk);
    addr_b = 6'd1; wdata_b = 24'hA0B0C0; we_c = 1'b0;
    @(negedge clk);
    we_b = 1'b0;

    // NumLeds=1: the only word is also the last
    upd_c = 1'b1;
    @(negedge clk);
    upd_c = 1'b0;
    n = 0;
    while (!valid_c && n < 20) begin @(negedge clk); n++; end
    check("c_word", {7'd0, last_c, data_c}, {7'd0, 1'b1, 24'h554466});

    // Scenario 1: basic frame
    write_a(6'd0, 24'hFF0000);
    write_a(6'd1, 24'h00FF00);
    clear_a();
    pulse_a();
    check("s1_go",   {31'd0, go_a},   32'd1);
    check("s1_busy", {31'd0, busy_a}, 32'd1);
    wait_idle_a("s1_done");
    check("s1_gocnt", go_cnt_a, 32'd1);
    check("s1_nword", words_a.size(), 32'd2);
    check("s1_w0", {7'd0, words_a[0]}, {7'd0, 1'b0, 24'h00FF00});
    check("s1_w1", {7'd0, words_a[1]}, {7'd0, 1'b1, 24'hFF0000});
    check("s1_idle", {31'd0, idle_a}, 32'd1);

    // Scenario 2: three requests during STREAM collapse to one extra frame
    clear_a();
    pulse_a();
    wait_valid_a("s2_valid");
    pulse_a();
    @(negedge clk);
    pulse_a();
    pulse_a();
    wait_idle_a("s2_done");
    check("s2_gocnt", go_cnt_a, 32'd2);
    check("s2_nword", words_a.size(), 32'd4);
    check("s2_gogap", go_gap_a, 32'd1);

    // Scenario 3: out-of-range write ignored; mid-frame write to an unsent LED goes out
    write_a(6'd5, 24'h123456);
    clear_a();
    pulse_a();
    wait_valid_a("s3_valid");
    write_a(6'd1, 24'h1122AA);
    wait_idle_a("s3_done");
    check("s3_w0", {7'd0, words_a[0]}, {7'd0, 1'b0, 24'h00FF00});
    check("s3_w1", {7'd0, words_a[1]}, {7'd0, 1'b1, 24'h2211AA});

    // Scenario 5: asynchronous reset mid-STREAM
    clear_a();
    pulse_a();
    wait_valid_a("s5_valid");
    #3 rst_a = 1'b0;
    #1;
    check("s5_valid0", {31'd0, valid_a}, 32'd0);
    check("s5_go0",    {31'd0, go_a},    32'd0);
    check("s5_last0",  {31'd0, last_a},  32'd0);
    check("s5_data0",  {8'd0, data_a},   32'd0);
    check("s5_busy0",  {31'd0, busy_a},  32'd0);
    @(negedge clk);
    #2 rst_a = 1'b1;
    clear_a();
    repeat (50) @(negedge clk);
    check("s5_nogo",  go_cnt_a, 32'd0);
    check("s5_idle",  {31'd0, busy_a}, 32'd0);
    pulse_a();
    wait_idle_a("s5_done");
    check("s5_w0", {7'd0, words_a[0]}, {7'd0, 1'b0, 24'h000000});
    check("s5_w1", {7'd0, words_a[1]}, {7'd0, 1'b1, 24'h000000});

    // Scenario 6: brightness 127
    bright_a = 8'd127;
    write_a(6'd0, 24'h80FF40);
    clear_a();
    pulse_a();
    wait_idle_a("s6_done");
`ifdef RGBLED_CTRL_BRIGHTNESS_EN
    check("s6_w0", {8'd0, words_a[0][23:0]}, 32'h007F4020);
`else
    check("s6_w0", {8'd0, words_a[0][23:0]}, 32'h00FF8040);
`endif

    // Scenario 4: refresh frames at 1000 and 2000 carry the current colours
    n = 0;
    while (cyc_b < 1010 && n < 3000) begin @(negedge clk); n++; end
    we_b = 1'b1; addr_b = 6'd0; wdata_b = 24'h010203;
    @(negedge clk);
    we_b = 1'b0;
    n = 0;
    while (cyc_b < 2010 && n < 3000) begin @(negedge clk); n++; end
    check("s4_ngo", gocyc_b.size(), 32'd2);
    check("s4_go1", gocyc_b[0], 32'd1000);
    check("s4_go2", gocyc_b[1], 32'd2000);
    check("s4_f1w0", {7'd0, words_b[0]}, {7'd0, 1'b0, 24'h221133});
    check("s4_f1w1", {7'd0, words_b[1]}, {7'd0, 1'b1, 24'hB0A0C0});
    check("s4_f2w0", {7'd0, words_b[2]}, {7'd0, 1'b0, 24'h020103});
    check("s4_f2w1", {7'd0, words_b[3]}, {7'd0, 1'b1, 24'hB0A0C0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
